// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared types and constants for the SPI master/slave pair.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package spi_pkg;

    localparam int SPI_DATA_WIDTH_DEFAULT = 32;
    localparam int SPI_MIN_HALF_PERIOD    = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        LOW   = 3'd2,
        HIGH  = 3'd3,
        HOLD  = 3'd4,
        GAP   = 3'd5
    } spi_state_t;

    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for signals asynchronous to clk.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/spi_master.sv
// ---------------------------------------------------------------------------
// spi_master
// SPI mode-0 master, one DATA_WIDTH-bit word per chip-select frame, MSB first.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spi_master
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = SPI_DATA_WIDTH_DEFAULT,
    parameter int CLK_DIV    = 4,
    parameter int CS_SETUP   = 8,
    parameter int CS_HOLD    = 4,
    parameter int CS_IDLE    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  spi_sclk,
    output logic                  spi_mosi,
    output logic                  spi_cs_n,
    input  logic                  spi_miso
);

    localparam int CNT_MAX = max_of4(CLK_DIV, CS_SETUP, CS_HOLD, CS_IDLE);
    localparam int DIV_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int BIT_W   = $clog2(DATA_WIDTH + 1);

    localparam logic [2:0] ST_IDLE  = IDLE;
    localparam logic [2:0] ST_SETUP = SETUP;
    localparam logic [2:0] ST_LOW   = LOW;
    localparam logic [2:0] ST_HIGH  = HIGH;
    localparam logic [2:0] ST_HOLD  = HOLD;
    localparam logic [2:0] ST_GAP   = GAP;

    localparam logic [DIV_W-1:0] C_LOAD_SETUP = DIV_W'(CS_SETUP - 1);
    localparam logic [DIV_W-1:0] C_LOAD_HALF  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] C_LOAD_HOLD  = DIV_W'(CS_HOLD - 1);
    localparam logic [DIV_W-1:0] C_LOAD_GAP   = DIV_W'(CS_IDLE - 1);
    localparam logic [BIT_W-1:0] C_LAST_BIT   = BIT_W'(DATA_WIDTH - 1);

    generate
        if (CLK_DIV < SPI_MIN_HALF_PERIOD) begin : g_bad_clk_div
            $error("spi_master: CLK_DIV must be >= %0d", SPI_MIN_HALF_PERIOD);
        end
        if (CS_SETUP < 1) begin : g_bad_cs_setup
            $error("spi_master: CS_SETUP must be >= 1");
        end
        if (CS_HOLD < 1) begin : g_bad_cs_hold
            $error("spi_master: CS_HOLD must be >= 1");
        end
        if (CS_IDLE < 4) begin : g_bad_cs_idle
            $error("spi_master: CS_IDLE must be >= 4");
        end
        if (DATA_WIDTH < 2) begin : g_bad_width
            $error("spi_master: DATA_WIDTH must be >= 2");
        end
    endgenerate

    logic [2:0]            r_state;
    logic [DIV_W-1:0]      r_div_cnt;
    logic [BIT_W-1:0]      r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift_tx;
    logic [DATA_WIDTH-1:0] r_shift_rx;
    logic [DATA_WIDTH-1:0] r_rx_data;
    logic                  r_rx_valid;
    logic                  r_sclk;
    logic                  r_mosi;
    logic                  r_cs_n;
    logic                  w_miso_s;
    logic                  w_div_done;

    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b0)
    ) u_miso_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (spi_miso),
        .o_q   (w_miso_s)
    );

    assign w_div_done = (r_div_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_div_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_shift_tx <= '0;
            r_shift_rx <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_cs_n     <= 1'b1;
        end else begin
            r_rx_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (tx_valid) begin
                        r_shift_tx <= tx_data;
                        r_shift_rx <= '0;
                        r_bit_cnt  <= '0;
                        r_div_cnt  <= C_LOAD_SETUP;
                        r_cs_n     <= 1'b0;
                        r_mosi     <= tx_data[DATA_WIDTH-1];
                        r_state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (w_div_done) begin
                        r_div_cnt <= C_LOAD_HALF;
                        r_state   <= ST_LOW;
                    end else begin
                        r_div_cnt <= r_div_cnt - DIV_W'(1);
                    end
                end
                ST_LOW: begin
                    if (w_div_done) begin
                        r_div_cnt <= C_LOAD_HALF;
                        r_sclk    <= 1'b1;
                        r_state   <= ST_HIGH;
                    end else begin
                        r_div_cnt <= r_div_cnt - DIV_W'(1);
                    end
                end
                ST_HIGH: begin
                    if (w_div_done) begin
                        // Sample late in HIGH so the slave's post-fall MISO update has settled.
                        r_shift_rx <= {r_shift_rx[DATA_WIDTH-2:0], w_miso_s};
                        r_bit_cnt  <= r_bit_cnt + BIT_W'(1);
                        r_sclk     <= 1'b0;
                        if (r_bit_cnt == C_LAST_BIT) begin
                            r_div_cnt <= C_LOAD_HOLD;
                            r_state   <= ST_HOLD;
                        end else begin
                            r_shift_tx <= r_shift_tx << 1;
                            r_mosi     <= r_shift_tx[DATA_WIDTH-2];
                            r_div_cnt  <= C_LOAD_HALF;
                            r_state    <= ST_LOW;
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt - DIV_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (w_div_done) begin
                        r_cs_n     <= 1'b1;
                        r_mosi     <= 1'b0;
                        r_rx_data  <= r_shift_rx;
                        r_rx_valid <= 1'b1;
                        r_div_cnt  <= C_LOAD_GAP;
                        r_state    <= ST_GAP;
                    end else begin
                        r_div_cnt <= r_div_cnt - DIV_W'(1);
                    end
                end
                ST_GAP: begin
                    // The idle countdown starts after the rx_valid cycle.
                    if (!r_rx_valid) begin
                        if (w_div_done) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_div_cnt <= r_div_cnt - DIV_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_ready = (r_state == ST_IDLE);
    assign busy     = (r_state != ST_IDLE);
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign spi_sclk = r_sclk;
    assign spi_mosi = r_mosi;
    assign spi_cs_n = r_cs_n;

endmodule

`default_nettype wire
